n64_mem_arbiter: RTL and testbench
==================================

# n64_mem_arbiter

Two-port arbiter placed directly downstream of the N64 PI bus interface. It merges the PI memory master (port A) and the MCU/DMA memory master (port B) onto the single 16-bit memory bus that drives the SDRAM controller. It latches one transaction at a time, holds ownership until the downstream ack, and returns the ack only to the owner. Port A has priority, with an optional starvation guard for port B.

## Interface

Parameters:
- MAX_A_STREAK, 8: number of consecutive port-A grants allowed while B is pending. Used only when the guard is compiled in. Range 1–15.

Ports (each mem_bus carries request, ack, write, address[31:0], wdata[15:0], rdata[15:0], wmask[1:0]):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bus_a  mem_bus.memory  —  PI master (priority port)
- bus_b  mem_bus.memory  —  MCU/DMA master
- mem  mem_bus.controller  —  to SDRAM controller
- owner  out  2  current owner: 00 none, 01 A, 10 B

## Operation

- States: IDLE, OWN_A, OWN_B.
- In IDLE, requests are sampled each cycle:
  - only A requesting → OWN_A
  - only B requesting → OWN_B
  - both requesting → A wins, unless the guard is active and streak == MAX_A_STREAK, in which case B wins
- On a grant edge:
  - capture the winner's write, address, wdata and wmask into the output registers
  - set mem.request to 1 and owner to the winner
- In OWN_x:
  - hold all captured fields constant; the masters' later changes are ignored
  - when mem.ack = 1: drive x.ack = 1 combinationally in the same cycle; the other port's ack stays 0
  - on the next edge: mem.request goes to 0, state goes to IDLE, owner goes to 00
- rdata: mem.rdata is broadcast to both bus_a.rdata and bus_b.rdata. It is valid only with the respective ack.
- Masters must hold request until they see ack and drop it on the edge after ack. The arbiter never re-grants in the ack cycle.
- Widths:
  - address, wdata and wmask pass through unmodified
  - no address decoding or translation is done here; offsets are applied upstream
- Reset values:
  - mem.request 0, mem.write 0, mem.address 0, mem.wdata 0, mem.wmask 00
  - owner 00, state IDLE, streak 0
  - bus_a.ack and bus_b.ack 0
- Reset mid-transaction:
  - return to IDLE immediately and drop mem.request
  - an ack arriving in the reset cycle is not forwarded
- An ack arriving while in IDLE (spurious) is ignored and never forwarded.

## Timing

- Grant latency: a request seen in IDLE at edge N produces mem.request = 1 after edge N.
- Ack passthrough: combinational, 0 cycles.
- Release: 1 cycle after ack (IDLE at the edge following the ack).
- Minimum back-to-back spacing: 2 cycles from one ack to the next mem.request rising.
  - Cycle N: ack.
  - Edge N+1: IDLE, sample requests.
  - Edge N+2: request.
- Simultaneous requests in the same cycle: resolved by the priority rule above. No cycle is lost.

## Configuration

- N64_MEM_ARBITER_STARVATION_GUARD_EN defined:
  - 4-bit streak counter
  - increments on each A grant while B.request = 1
  - clears on any B grant or in any IDLE cycle with B.request = 0
  - saturates at MAX_A_STREAK
- Not defined:
  - strict A priority; B waits indefinitely while A keeps requesting
  - no counter logic is synthesized

## Structure

- Shared package sc64_pkg:
  - e_mem_owner enum (OWNER_NONE = 2'b00, OWNER_A = 2'b01, OWNER_B = 2'b10); owner is driven from it
  - state enum e_mem_arb_state (IDLE, OWN_A, OWN_B)
- Single module. No sub-module; the selector and streak counter are too small to split out.

## Test plan

- A-only write: A request with address 0x0000_1000, wdata 0xBEEF, mem ack 3 cycles later → mem sees a single write with that address/data; A.ack for exactly 1 cycle; B.ack stays 0; owner 01 then 00.
- Simultaneous A and B reads in the same cycle → A is served first (owner 01), then B; B.rdata equals mem.rdata 0x1234 during B's ack only.
- Field hold: A changes address from 0x10 to 0x20 mid-transaction → mem.address stays 0x10 until ack.
- Guard on, MAX_A_STREAK = 8: A continuously requesting, B pending → B is granted after exactly 8 A grants; streak returns to 0. Guard off → B is never granted during the 100-cycle A burst.
- Reset asserted while in OWN_B with ack coinciding → B.ack stays 0; all outputs at reset values the next cycle.
- Spurious mem ack in IDLE → neither port acked; state remains IDLE.

Source files
------------

// File: rtl/sc64_pkg.sv
// Shared SC64 types: memory-bus owner encoding and the arbiter state set.
package sc64_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_A    = 2'b01,
        OWNER_B    = 2'b10
    } e_mem_owner;

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } e_mem_arb_state;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_bus.sv
// 16-bit memory bus: a controller drives the request side, a memory answers with ack/rdata.
interface mem_bus;
    logic        request;
    logic        ack;
    logic        write;
    logic [31:0] address;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [1:0]  wmask;

    modport controller (
        output request, write, address, wdata, wmask,
        input  ack, rdata
    );

    modport memory (
        input  request, write, address, wdata, wmask,
        output ack, rdata
    );
endinterface

// File: rtl/n64_mem_arbiter.sv
// Two-port memory arbiter: PI master (A, priority) and MCU/DMA master (B) onto one bus.
// Define N64_MEM_ARBITER_STARVATION_GUARD_EN to let B win after MAX_A_STREAK contested A grants.
module n64_mem_arbiter
    import sc64_pkg::*;
#(
    parameter int MAX_A_STREAK = 8
) (
    input  logic       clk,
    input  logic       reset,
    mem_bus.memory     bus_a,
    mem_bus.memory     bus_b,
    mem_bus.controller mem,
    output e_mem_owner owner
);

    e_mem_arb_state r_state;
    e_mem_owner     r_owner;
    logic           r_request;
    logic           r_write;
    logic [31:0]    r_address;
    logic [15:0]    r_wdata;
    logic [1:0]     r_wmask;

    logic w_force_b;
    logic w_pick_a;
    logic w_pick_b;

`ifdef N64_MEM_ARBITER_STARVATION_GUARD_EN
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_A_STREAK);

    logic [STREAK_W-1:0] r_streak;

    assign w_force_b = (r_streak == STREAK_MAX);

    // Counts A grants that B had to wait through; only IDLE cycles can grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_b || !bus_b.request) begin
                r_streak <= '0;
            end else if (w_pick_a && r_streak != STREAK_MAX) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end
`else
    logic w_unused_max_a_streak;

    assign w_unused_max_a_streak = |STREAK_W'(MAX_A_STREAK);
    assign w_force_b             = 1'b0;
`endif

    assign w_pick_b = bus_b.request && (!bus_a.request || w_force_b);
    assign w_pick_a = bus_a.request && !w_pick_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= OWNER_NONE;
            r_request <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_a) begin
                        r_state   <= OWN_A;
                        r_owner   <= OWNER_A;
                        r_request <= 1'b1;
                        r_write   <= bus_a.write;
                        r_address <= bus_a.address;
                        r_wdata   <= bus_a.wdata;
                        r_wmask   <= bus_a.wmask;
                    end else if (w_pick_b) begin
                        r_state   <= OWN_B;
                        r_owner   <= OWNER_B;
                        r_request <= 1'b1;
                        r_write   <= bus_b.write;
                        r_address <= bus_b.address;
                        r_wdata   <= bus_b.wdata;
                        r_wmask   <= bus_b.wmask;
                    end
                end
                OWN_A, OWN_B: begin
                    // Captured fields stay put; release one cycle after the ack.
                    if (mem.ack) begin
                        r_state   <= IDLE;
                        r_owner   <= OWNER_NONE;
                        r_request <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_owner   <= OWNER_NONE;
                    r_request <= 1'b0;
                end
            endcase
        end
    end

    assign mem.request = r_request;
    assign mem.write   = r_write;
    assign mem.address = r_address;
    assign mem.wdata   = r_wdata;
    assign mem.wmask   = r_wmask;

    // Ack is routed only to the owner and suppressed while reset is asserted.
    assign bus_a.ack   = !reset && (r_state == OWN_A) && mem.ack;
    assign bus_b.ack   = !reset && (r_state == OWN_B) && mem.ack;
    assign bus_a.rdata = mem.rdata;
    assign bus_b.rdata = mem.rdata;

    assign owner = r_owner;

endmodule

// File: tb/tb_n64_mem_arbiter.sv
// Randomized bench for n64_mem_arbiter against a transaction-level ownership model.
module tb_n64_mem_arbiter;
    import sc64_pkg::*;

    localparam int MAXS = 8;
`ifdef N64_MEM_ARBITER_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    e_mem_owner owner;

    mem_bus bus_a ();
    mem_bus bus_b ();
    mem_bus mem ();

    always #5 clk = ~clk;

    n64_mem_arbiter #(.MAX_A_STREAK(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_a (bus_a),
        .bus_b (bus_b),
        .mem   (mem),
        .owner (owner)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus and what was captured at grant time.
    int          m_own;
    int          m_streak;
    logic        m_write;
    logic [31:0] m_addr;
    logic [15:0] m_wdata;
    logic [1:0]  m_wmask;
    logic [15:0] drv_rdata;
    int          lat;
    int          done_a;
    int          done_b;
    bit          a_seen_ack;
    bit          b_seen_ack;

    task automatic rand_fields(output logic w, output logic [31:0] ad,
                               output logic [15:0] d, output logic [1:0] m);
        w  = 1'($urandom);
        ad = $urandom;
        d  = 16'($urandom);
        m  = 2'($urandom);
    endtask

    task automatic drive(input int pa, input int pb, input int prst_pm);
        reset = ($urandom_range(999, 0) < prst_pm);
        if (bus_a.request) begin
            if (a_seen_ack) begin
                done_a++;
                if ($urandom_range(99, 0) < pa)
                    rand_fields(bus_a.write, bus_a.address, bus_a.wdata, bus_a.wmask);
                else
                    bus_a.request = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
                rand_fields(bus_a.write, bus_a.address, bus_a.wdata, bus_a.wmask);
            end
        end else if ($urandom_range(99, 0) < pa) begin
            bus_a.request = 1'b1;
            rand_fields(bus_a.write, bus_a.address, bus_a.wdata, bus_a.wmask);
        end
        if (bus_b.request) begin
            if (b_seen_ack) begin
                done_b++;
                if ($urandom_range(99, 0) < pb)
                    rand_fields(bus_b.write, bus_b.address, bus_b.wdata, bus_b.wmask);
                else
                    bus_b.request = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
                rand_fields(bus_b.write, bus_b.address, bus_b.wdata, bus_b.wmask);
            end
        end else if ($urandom_range(99, 0) < pb) begin
            bus_b.request = 1'b1;
            rand_fields(bus_b.write, bus_b.address, bus_b.wdata, bus_b.wmask);
        end
        // Memory side: random ack latency, plus occasional spurious acks when idle.
        if (mem.request) begin
            if (lat == 0) begin
                mem.ack = 1'b1;
                lat = $urandom_range(3, 0);
            end else begin
                mem.ack = 1'b0;
                lat--;
            end
        end else begin
            mem.ack = ($urandom_range(7, 0) == 0);
        end
        drv_rdata = 16'($urandom);
        mem.rdata = drv_rdata;
    endtask

    task automatic check_and_step();
        bit exp_ack_a;
        bit exp_ack_b;
        bit ra;
        bit rb;
        int win;
        exp_ack_a = !reset && (m_own == 1) && mem.ack;
        exp_ack_b = !reset && (m_own == 2) && mem.ack;
        chk("owner", 32'(owner), 32'(m_own));
        chk("mem_request", 32'(mem.request), 32'(m_own != 0));
        chk("mem_address", mem.address, m_addr);
        chk("mem_wdata", 32'(mem.wdata), 32'(m_wdata));
        chk("mem_write_wmask", 32'({mem.write, mem.wmask}), 32'({m_write, m_wmask}));
        chk("ack_a", 32'(bus_a.ack), 32'(exp_ack_a));
        chk("ack_b", 32'(bus_b.ack), 32'(exp_ack_b));
        if (exp_ack_a) chk("rdata_a", 32'(bus_a.rdata), 32'(drv_rdata));
        if (exp_ack_b) chk("rdata_b", 32'(bus_b.rdata), 32'(drv_rdata));
        a_seen_ack = bus_a.ack;
        b_seen_ack = bus_b.ack;

        ra = bus_a.request;
        rb = bus_b.request;
        if (reset) begin
            m_own = 0; m_streak = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0;
        end else if (m_own == 0) begin
            win = 0;
            if (ra && rb) win = (GUARD && m_streak == MAXS) ? 2 : 1;
            else if (ra)  win = 1;
            else if (rb)  win = 2;
            if (win == 2 || !rb) m_streak = 0;
            else if (win == 1 && m_streak < MAXS) m_streak++;
            if (win == 1) begin
                m_write = bus_a.write; m_addr = bus_a.address;
                m_wdata = bus_a.wdata; m_wmask = bus_a.wmask;
            end else if (win == 2) begin
                m_write = bus_b.write; m_addr = bus_b.address;
                m_wdata = bus_b.wdata; m_wmask = bus_b.wmask;
            end
            m_own = win;
        end else if (mem.ack) begin
            m_own = 0;
        end
    endtask

    initial begin
        bus_a.request = 1'b0; bus_a.write = 1'b0; bus_a.address = '0; bus_a.wdata = '0; bus_a.wmask = '0;
        bus_b.request = 1'b0; bus_b.write = 1'b0; bus_b.address = '0; bus_b.wdata = '0; bus_b.wmask = '0;
        mem.ack = 1'b1;
        mem.rdata = 16'h1234;
        drv_rdata = 16'h1234;
        lat = 0; done_a = 0; done_b = 0;
        a_seen_ack = 1'b0; b_seen_ack = 1'b0;
        m_own = 0; m_streak = 0;
        m_write = 1'b0; m_addr = '0; m_wdata = '0; m_wmask = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'(OWNER_NONE));
        chk("rst_request", 32'(mem.request), 32'd0);
        chk("rst_address", mem.address, 32'd0);
        chk("rst_wdata_write_wmask", 32'({mem.wdata, mem.write, mem.wmask}), 32'd0);
        chk("rst_acks", 32'({bus_a.ack, bus_b.ack}), 32'd0);
        mem.ack = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 2500) drive(35, 35, 5);
            else            drive(100, 60, 0);
            @(negedge clk);
            check_and_step();
        end

        chk("a_progress", 32'(done_a > 0), 32'd1);
        chk("b_progress", 32'(done_b > 0), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
